// File: rtl/br_predict_unit_pkg.sv
// Shared definitions for the branch prediction unit: the branch-code encodings,
// the default datapath width and the 2-bit counter helper.
package br_predict_unit_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [3:0] {
    CB_NONE    = 4'd0,
    CB_J_BR    = 4'd1,
    CB_BEQ_BR  = 4'd2,
    CB_BNE_BR  = 4'd3,
    CB_BLEZ_BR = 4'd4,
    CB_BGTZ_BR = 4'd5,
    CB_BLTZ_BR = 4'd6,
    CB_BGEZ_BR = 4'd7,
    CB_JAL_BR  = 4'd8,
    CB_JR_BR   = 4'd9
  } cb_e;

  localparam logic [1:0] CNT_INIT  = 2'b01;
  localparam logic [1:0] CNT_ALLOC = 2'b10;

  // Saturating 2-bit counter step: up on taken, down on not-taken.
  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    if (up) begin
      res = (cnt == 2'd3) ? cnt : cnt + 2'd1;
    end else begin
      res = (cnt == 2'd0) ? cnt : cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/br_predict_unit_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch prediction unit.
// Statistics outputs are present only when BR_PREDICT_STATS_EN is defined.
interface br_predict_unit_if #(
  parameter int XLEN = br_predict_unit_pkg::XLEN_DEF
);
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pred_npc;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [3:0]      ex_cb;
  logic [25:0]     ex_instr_index;
  logic [15:0]     ex_offset;
  logic [XLEN-1:0] ex_rs;
  logic [XLEN-1:0] ex_rt;
  logic [XLEN-1:0] ex_pred_npc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            ra_we;
  logic [XLEN-1:0] ra;
`ifdef BR_PREDICT_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  modport master (
    output if_pc, ex_valid, ex_pc, ex_cb, ex_instr_index, ex_offset, ex_rs, ex_rt, ex_pred_npc,
    input  if_pred_npc, redirect_valid, redirect_pc, ra_we, ra
`ifdef BR_PREDICT_STATS_EN
    , input stat_branches, input stat_mispredicts
`endif
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_cb, ex_instr_index, ex_offset, ex_rs, ex_rt, ex_pred_npc,
    output if_pred_npc, redirect_valid, redirect_pc, ra_we, ra
`ifdef BR_PREDICT_STATS_EN
    , output stat_branches, output stat_mispredicts
`endif
  );

endinterface

// File: rtl/br_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// The lookup reads pre-update contents when it hits the index being written.
module br_btb
  import br_predict_unit_pkg::*;
#(
  parameter  int XLEN    = XLEN_DEF,
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_pred,
  output logic [XLEN-1:0]  lk_target,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic             upd_cond,
  input  logic             upd_taken,
  input  logic             upd_uncond,
  input  logic [XLEN-1:0]  upd_target
);

  logic            valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r   [ENTRIES];
  logic [XLEN-1:0] target_r [ENTRIES];
  logic            uncond_r [ENTRIES];
  logic [1:0]      cnt_r    [ENTRIES];

  logic lk_hit_s;
  logic upd_hit_s;

  assign lk_hit_s  = valid_r[lk_idx] && (tag_r[lk_idx] == lk_tag);
  assign lk_pred   = lk_hit_s && (uncond_r[lk_idx] || cnt_r[lk_idx][1]);
  assign lk_target = target_r[lk_idx];
  assign upd_hit_s = valid_r[upd_idx] && (tag_r[upd_idx] == upd_tag);

  // Entry storage: train on a hit, allocate on a taken miss (evicting the occupant).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= '0;
        uncond_r[i] <= 1'b0;
        cnt_r[i]    <= CNT_INIT;
      end
    end else if (upd_en) begin
      if (upd_hit_s) begin
        if (upd_cond) begin
          cnt_r[upd_idx] <= sat_cnt(cnt_r[upd_idx], upd_taken);
        end
        target_r[upd_idx] <= upd_target;
        uncond_r[upd_idx] <= upd_uncond;
      end else if (upd_taken) begin
        valid_r[upd_idx]  <= 1'b1;
        tag_r[upd_idx]    <= upd_tag;
        target_r[upd_idx] <= upd_target;
        uncond_r[upd_idx] <= upd_uncond;
        cnt_r[upd_idx]    <= CNT_ALLOC;
      end
    end
  end

endmodule

// File: rtl/br_predict_unit.sv
// Branch unit: IF-stage BTB next-PC prediction, EX-stage resolution and a registered
// one-cycle redirect. Define BR_PREDICT_STATS_EN to add branch/mispredict counters.
module br_predict_unit
  import br_predict_unit_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int BTB_ENTRIES = 16
) (
  input logic              clk,
  input logic              rst,
  br_predict_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  cb_e             cb_s;
  logic [XLEN-1:0] npc_s, br_s, jmp_s, tgt_s, actual_s, upd_target_s;
  logic [XLEN-1:0] lk_target_s;
  logic            lk_pred_s;
  logic            taken_s, cond_s, is_br_s;
  logic            rs_neg_s, rs_zero_s;
  logic            live_s, mispredict_s, link_s, upd_en_s;
  logic            redirect_valid_r, ra_we_r;
  logic [XLEN-1:0] redirect_pc_r, ra_r;

  assign cb_s      = cb_e'(bus.ex_cb);
  assign npc_s     = bus.ex_pc + XLEN'(32'd4);
  assign br_s      = npc_s + {{(XLEN-18){bus.ex_offset[15]}}, bus.ex_offset, 2'b00};
  assign jmp_s     = {bus.ex_pc[XLEN-1:28], bus.ex_instr_index, 2'b00};
  assign rs_neg_s  = bus.ex_rs[XLEN-1];
  assign rs_zero_s = (bus.ex_rs == '0);

  // Branch-code decode: taken decision and the non-conditional target.
  always_comb begin
    tgt_s   = npc_s;
    taken_s = 1'b0;
    cond_s  = 1'b0;
    is_br_s = 1'b1;
    case (cb_s)
      CB_J_BR, CB_JAL_BR: begin taken_s = 1'b1; tgt_s = jmp_s; end
      CB_JR_BR:           begin taken_s = 1'b1; tgt_s = bus.ex_rs; end
      CB_BEQ_BR:          begin cond_s = 1'b1; taken_s = (bus.ex_rs == bus.ex_rt); end
      CB_BNE_BR:          begin cond_s = 1'b1; taken_s = (bus.ex_rs != bus.ex_rt); end
      CB_BLEZ_BR:         begin cond_s = 1'b1; taken_s = rs_neg_s || rs_zero_s; end
      CB_BGTZ_BR:         begin cond_s = 1'b1; taken_s = !rs_neg_s && !rs_zero_s; end
      CB_BLTZ_BR:         begin cond_s = 1'b1; taken_s = rs_neg_s; end
      CB_BGEZ_BR:         begin cond_s = 1'b1; taken_s = !rs_neg_s; end
      default:            is_br_s = 1'b0;
    endcase
  end

  assign actual_s     = (cond_s && taken_s) ? br_s : tgt_s;
  // Conditional entries always remember the taken target, even when trained not-taken.
  assign upd_target_s = cond_s ? br_s : tgt_s;
  assign live_s       = bus.ex_valid && !redirect_valid_r;
  assign mispredict_s = live_s && (actual_s != bus.ex_pred_npc);
  assign link_s       = live_s && (cb_s == CB_JAL_BR);
  assign upd_en_s     = live_s && is_br_s && (cb_s != CB_JR_BR);

  br_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lk_idx     (bus.if_pc[IDX_W+1:2]),
    .lk_tag     (bus.if_pc[XLEN-1:IDX_W+2]),
    .lk_pred    (lk_pred_s),
    .lk_target  (lk_target_s),
    .upd_en     (upd_en_s),
    .upd_idx    (bus.ex_pc[IDX_W+1:2]),
    .upd_tag    (bus.ex_pc[XLEN-1:IDX_W+2]),
    .upd_cond   (cond_s),
    .upd_taken  (taken_s),
    .upd_uncond (!cond_s),
    .upd_target (upd_target_s)
  );

  assign bus.if_pred_npc = lk_pred_s ? lk_target_s : bus.if_pc + XLEN'(32'd4);

  // Registered redirect and link outputs; redirect_pc and ra hold between events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
      ra_we_r          <= 1'b0;
      ra_r             <= '0;
    end else begin
      redirect_valid_r <= mispredict_s;
      redirect_pc_r    <= mispredict_s ? actual_s : redirect_pc_r;
      ra_we_r          <= link_s;
      ra_r             <= link_s ? bus.ex_pc + XLEN'(32'd8) : ra_r;
    end
  end

  assign bus.redirect_valid = redirect_valid_r;
  assign bus.redirect_pc    = redirect_pc_r;
  assign bus.ra_we          = ra_we_r;
  assign bus.ra             = ra_r;

`ifdef BR_PREDICT_STATS_EN
  logic [31:0] stat_branches_r, stat_mispredicts_r;

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_r    <= 32'd0;
      stat_mispredicts_r <= 32'd0;
    end else begin
      stat_branches_r    <= (live_s && is_br_s) ? stat_branches_r + 32'd1 : stat_branches_r;
      stat_mispredicts_r <= mispredict_s ? stat_mispredicts_r + 32'd1 : stat_mispredicts_r;
    end
  end

  assign bus.stat_branches    = stat_branches_r;
  assign bus.stat_mispredicts = stat_mispredicts_r;
`endif

endmodule

// File: tb/tb_br_predict_unit.sv
// Self-checking bench for br_predict_unit: directed vectors, a behavioural model
// compared every cycle, and hand-computed literal expectations.
module tb_br_predict_unit;
  import br_predict_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  br_predict_unit_if #(.XLEN(32)) bus ();
  br_predict_unit #(.XLEN(32), .BTB_ENTRIES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit        valid;
    bit [31:0] pc;
    bit [31:0] target;
    bit        uncond;
    int        cnt;
  } ent_t;

  ent_t        m_btb [16];
  bit          m_rv, m_rawe;
  bit [31:0]   m_rpc, m_ra;
  int unsigned m_nbr, m_nmis;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic int idx_of(bit [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit [31:0] model_pred(bit [31:0] pc);
    ent_t e;
    e = m_btb[idx_of(pc)];
    if (e.valid && e.pc[31:2] == pc[31:2] && (e.uncond || e.cnt >= 2)) return e.target;
    return pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_btb[i] = '{1'b0, 32'd0, 32'd0, 1'b0, 1};
    m_rv = 1'b0; m_rpc = 32'd0; m_rawe = 1'b0; m_ra = 32'd0;
    m_nbr = 0; m_nmis = 0;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("pred", bus.if_pred_npc, model_pred(bus.if_pc));
    check("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, m_rv});
    if (m_rv) check("redirect_pc", bus.redirect_pc, m_rpc);
    check("ra_we", {31'd0, bus.ra_we}, {31'd0, m_rawe});
    check("ra", bus.ra, m_ra);
`ifdef BR_PREDICT_STATS_EN
    check("stat_branches", bus.stat_branches, m_nbr);
    check("stat_mispredicts", bus.stat_mispredicts, m_nmis);
`endif
  endtask

  task automatic set_ex(bit v, bit [31:0] pc, logic [3:0] cb, bit [25:0] idx, bit [15:0] off,
                        bit [31:0] rs, bit [31:0] rt, bit [31:0] pred);
    bus.ex_valid = v; bus.ex_pc = pc; bus.ex_cb = cb; bus.ex_instr_index = idx;
    bus.ex_offset = off; bus.ex_rs = rs; bus.ex_rt = rt; bus.ex_pred_npc = pred;
  endtask

  // One clock: compare, resolve the EX instruction from the rules, advance the model.
  task automatic tick();
    bit [31:0] pc, rs, rt, npc, br, actual, off32;
    bit taken, cond, isbr, live, nrv, nrawe;
    int cb, k;
    #1;
    compare_all();
    pc = bus.ex_pc; rs = bus.ex_rs; rt = bus.ex_rt; cb = int'(bus.ex_cb);
    npc = pc + 32'd4;
    off32 = {{16{bus.ex_offset[15]}}, bus.ex_offset};
    br = npc + (off32 << 2);
    taken = 1'b0; cond = 1'b0; isbr = 1'b1; actual = npc;
    case (cb)
      1, 8: begin taken = 1'b1; actual = {pc[31:28], bus.ex_instr_index, 2'b00}; end
      9:    begin taken = 1'b1; actual = rs; end
      2:    begin cond = 1'b1; taken = (rs == rt); end
      3:    begin cond = 1'b1; taken = (rs != rt); end
      4:    begin cond = 1'b1; taken = ($signed(rs) <= 0); end
      5:    begin cond = 1'b1; taken = ($signed(rs) > 0); end
      6:    begin cond = 1'b1; taken = ($signed(rs) < 0); end
      7:    begin cond = 1'b1; taken = ($signed(rs) >= 0); end
      default: isbr = 1'b0;
    endcase
    if (cond && taken) actual = br;
    live  = bus.ex_valid && !m_rv;
    nrv   = live && (actual != bus.ex_pred_npc);
    nrawe = live && (cb == 8);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (live && isbr) m_nbr++;
      if (nrv) begin m_nmis++; m_rpc = actual; end
      m_rv = nrv;
      m_rawe = nrawe;
      if (nrawe) m_ra = pc + 32'd8;
      if (live && isbr && cb != 9) begin
        k = idx_of(pc);
        if (m_btb[k].valid && m_btb[k].pc[31:2] == pc[31:2]) begin
          if (cond) m_btb[k].cnt = taken ? ((m_btb[k].cnt >= 3) ? 3 : m_btb[k].cnt + 1)
                                         : ((m_btb[k].cnt <= 0) ? 0 : m_btb[k].cnt - 1);
          m_btb[k].target = cond ? br : actual;
          m_btb[k].uncond = !cond;
        end else if (taken) begin
          m_btb[k] = '{1'b1, pc, cond ? br : actual, !cond, 2};
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic bubble();
    set_ex(1'b0, 32'd0, CB_NONE, 26'd0, 16'd0, 32'd0, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    bus.if_pc = 32'h0040_0000;
    set_ex(1'b0, 32'd0, CB_NONE, 26'd0, 16'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("reset_pred", bus.if_pred_npc, 32'h0040_0004);
    check("reset_rv", {31'd0, bus.redirect_valid}, 32'd0);
    check("reset_ra", bus.ra, 32'd0);
    rst = 1'b0;

    // beq taken, first encounter: mispredict and allocate
    bus.if_pc = 32'h100;
    set_ex(1'b1, 32'h100, CB_BEQ_BR, 26'd0, 16'h0004, 32'd5, 32'd5, 32'h104);
    tick();
    check("beq_rv", {31'd0, bus.redirect_valid}, 32'd1);
    check("beq_rpc", bus.redirect_pc, 32'h114);
    check("beq_pred", bus.if_pred_npc, 32'h114);
    bubble();
    check("beq_pulse", {31'd0, bus.redirect_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      set_ex(1'b1, 32'h100, CB_BEQ_BR, 26'd0, 16'h0004, 32'd5, 32'd5, 32'h114);
      tick();
      check("beq_hit_rv", {31'd0, bus.redirect_valid}, 32'd0);
    end
    set_ex(1'b1, 32'h100, CB_BEQ_BR, 26'd0, 16'h0004, 32'd5, 32'd6, 32'h114);
    tick();
    check("beq_nt_rpc", bus.redirect_pc, 32'h104);
    check("beq_cnt2_pred", bus.if_pred_npc, 32'h114);
    bubble();

    // signed single-operand branches; all alias index 0
    set_ex(1'b1, 32'h200, CB_BLTZ_BR, 26'd0, 16'h0010, 32'hFFFF_FFFF, 32'd0, 32'h204);
    tick();
    check("bltz_rpc", bus.redirect_pc, 32'h244);
    bubble();
    bus.if_pc = 32'h100;
    #1;
    check("evicted_pred", bus.if_pred_npc, 32'h104);
    set_ex(1'b1, 32'h300, CB_BLEZ_BR, 26'd0, 16'hFFFF, 32'd0, 32'd0, 32'h304);
    tick();
    check("blez_rpc", bus.redirect_pc, 32'h300);
    bubble();
    bus.if_pc = 32'h400;
    set_ex(1'b1, 32'h400, CB_BGTZ_BR, 26'd0, 16'h0008, 32'h8000_0000, 32'd0, 32'h404);
    tick();
    check("bgtz_rv", {31'd0, bus.redirect_valid}, 32'd0);
    check("bgtz_pred", bus.if_pred_npc, 32'h404);

    // jal with link, then a squashed wrong-path bne
    bus.if_pc = 32'h0040_0020;
    set_ex(1'b1, 32'h0040_0020, CB_JAL_BR, 26'h10_0000, 16'd0, 32'd0, 32'd0, 32'h0040_0024);
    tick();
    check("jal_rpc", bus.redirect_pc, 32'h0040_0000);
    check("jal_ra_we", {31'd0, bus.ra_we}, 32'd1);
    check("jal_ra", bus.ra, 32'h0040_0028);
    check("jal_pred", bus.if_pred_npc, 32'h0040_0000);
    bus.if_pc = 32'h500;
    set_ex(1'b1, 32'h500, CB_BNE_BR, 26'd0, 16'h0004, 32'd1, 32'd2, 32'h504);
    tick();
    check("squash_rv", {31'd0, bus.redirect_valid}, 32'd0);
    check("squash_ra_we", {31'd0, bus.ra_we}, 32'd0);
    check("squash_ra_hold", bus.ra, 32'h0040_0028);
    check("squash_pred", bus.if_pred_npc, 32'h504);

    // jr on the jal's index: redirect but entry left alone
    bus.if_pc = 32'h0040_0020;
    set_ex(1'b1, 32'h0040_0060, CB_JR_BR, 26'd0, 16'd0, 32'h1234, 32'd0, 32'h0040_0064);
    tick();
    check("jr_rpc", bus.redirect_pc, 32'h1234);
    check("jr_keep_pred", bus.if_pred_npc, 32'h0040_0000);
    bubble();

    // unknown branch code falls through to pc+4
    set_ex(1'b1, 32'h800, 4'hF, 26'd0, 16'h0004, 32'd0, 32'd0, 32'h804);
    tick();
    check("unknown_rv", {31'd0, bus.redirect_valid}, 32'd0);

    // reset asserted while a redirect is on the outputs
    set_ex(1'b1, 32'h700, CB_BGEZ_BR, 26'd0, 16'h0004, 32'd0, 32'd0, 32'h704);
    tick();
    check("bgez_rpc", bus.redirect_pc, 32'h714);
    rst = 1'b1;
    bus.if_pc = 32'h0040_0020;
    set_ex(1'b0, 32'd0, CB_NONE, 26'd0, 16'd0, 32'd0, 32'd0, 32'd0);
    #1;
    model_reset();
    check("midrst_rv", {31'd0, bus.redirect_valid}, 32'd0);
    check("midrst_pred", bus.if_pred_npc, 32'h0040_0024);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_pred", bus.if_pred_npc, 32'h0040_0024);
    bubble();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/br_predict_unit.md
Name: br_predict_unit

Overview:
- Next-generation branch unit. Adds a parametrised direct-mapped BTB with 2-bit saturating counters for IF-stage next-PC prediction.
- Performs EX-stage branch resolution for all CB codes and detects mispredictions.
- Issues a registered one-cycle redirect/flush to the PC mux and hazard unit.
- Replaces purely combinational next-PC selection; sits between the IF PC register and the EX stage.

Parameters:
- XLEN, 32, datapath/PC width; must be >= 32.
- BTB_ENTRIES, 16, BTB depth; power of two, 2 to 256.
- IDX_W, $clog2(BTB_ENTRIES), derived index width; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  XLEN  fetch PC for lookup.
- if_pred_npc  out  XLEN  predicted next fetch PC (combinational from if_pc).
- ex_valid  in  1  EX holds a live, non-stalled instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_cb  in  4  branch code (none/j/beq/bne/blez/bgtz/bltz/bgez/jal/jr).
- ex_instr_index  in  26  J-type index.
- ex_offset  in  16  branch offset.
- ex_rs  in  XLEN  RD1 operand.
- ex_rt  in  XLEN  RD2 operand.
- ex_pred_npc  in  XLEN  if_pred_npc piped down with the instruction.
- redirect_valid  out  1  flush and load redirect_pc; registered, 1-cycle pulse.
- redirect_pc  out  XLEN  corrected next PC.
- ra_we  out  1  registered link write enable.
- ra  out  XLEN  registered link value.

Behaviour:
- Reset (async): all BTB valid bits 0, all counters 2'b01, redirect_valid 0, redirect_pc 0, ra_we 0, ra 0, stats 0.
- BTB entry: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN], uncond bit, cnt[2]. Index = pc[IDX_W+1:2].
- Lookup is combinational. if_pred_npc = entry.target when hit && (uncond || cnt[1]); otherwise if_pc+4.
- Resolution:
  - npc = ex_pc+4.
  - br = ex_pc+4+sext(offset<<2).
  - j/jal target = {ex_pc[XLEN-1:28], index, 2'b00}.
  - jr target = ex_rs.
  - beq/bne compare rs vs rt.
  - blez/bgtz/bltz/bgez compare ex_rs as SIGNED against 0. Comparisons are always signed.
  - CB none or unknown: actual = npc.
- Mispredict = ex_valid && actual_npc != ex_pred_npc. On the next edge: redirect_valid=1, redirect_pc=actual_npc. redirect_valid is held for exactly one cycle.
- Squash rule: in any cycle where redirect_valid=1, ex_valid is ignored (wrong-path instruction). No BTB update, no redirect, no ra_we.
- Link: on a jal or jal-class resolution, the next edge gives ra_we=1 and ra=ex_pc+8. Otherwise ra_we=0 and ra holds its value.
- BTB update at the clock edge, when ex_valid, not squashed, and cb != none:
  - Hit, conditional branch: cnt saturates up on taken (max 3), down on not-taken (min 0). Target rewritten.
  - Miss, taken: allocate with cnt=2'b10, tag and target, uncond = (j|jal). The previous occupant is evicted.
  - Miss, not-taken: no allocation.
  - jr: never allocated. An existing entry at that index is left untouched.
- Same-cycle lookup and update on the same index: lookup returns the pre-update contents (write-after-read).
- Reset asserted mid-operation clears state immediately. The first cycle after deassert predicts pc+4 for every PC.

Optional Feature:
- Macro BR_PREDICT_STATS_EN.
  - Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0]. These count non-squashed ex_valid instructions with cb != none, and the redirects issued, respectively. Both wrap modulo 2^32 and are cleared by rst.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared branch-code header holds the CB encodings (none, j_br, beq_br, bne_br, blez_br, bgtz_br, bltz_br, bgez_br, jal_br, jr_br). The XLEN default also goes there.
- Sub-module br_btb: storage array, lookup port, update port, counter saturation.
- Resolution and redirect logic stay in the top module.

Test Plan:
- Reset, then if_pc=0x0040_0000 -> if_pred_npc=0x0040_0004; redirect_valid=0; ra=0.
- beq at 0x100, offset 0x0004, rs=rt=5, ex_pred_npc=0x104 -> next cycle redirect_valid=1, redirect_pc=0x114. A later if_pc=0x100 predicts 0x114.
- Same beq taken twice more, then not-taken with ex_pred_npc=0x114 -> redirect_pc=0x104. cnt path 2→3→3→2; lookup still predicts 0x114.
- bltz with rs=0xFFFF_FFFF -> taken, signed. blez with rs=0 -> taken. bgtz with rs=0x8000_0000 -> not taken.
- jal at 0x0040_0020, index 0x10_0000 -> redirect_pc=0x0040_0000, ra_we=1 and ra=0x0040_0028 for one cycle. A second mispredicting ex_valid in the redirect cycle is ignored.
- Assert rst mid-redirect -> redirect_valid drops immediately; the prior BTB hit now predicts pc+4.
